alu_mul_seq: RTL
================

# alu_mul_seq

Iterative 8×8 unsigned multiplier sequencer that sits directly upstream of the ALU. It drives the ALU operand inputs and add/sub select, and consumes the combinational `ans` to build a 16-bit product with shift-and-add over 8 iterations. A start/busy/done handshake lets the control unit issue one multiply and stall until the product is valid. The block reuses the ALU adder, so it holds no adder of its own.

## Interface
- `WIDTH`, default 8: operand width. The product is 2·WIDTH. The iteration count equals WIDTH.
- `flag_clk`  in  1: clock, shared with the ALU flag register.
- `flag_clr`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request a multiply. Sampled only in IDLE.
- `mcand`  in  WIDTH: multiplicand. Latched when start is accepted.
- `mplier`  in  WIDTH: multiplier. Latched when start is accepted.
- `alu_ans`  in  WIDTH: combinational ALU result (ALU `ans`).
- `alu_a`  out  WIDTH: ALU operand a (accumulator high half).
- `alu_b`  out  WIDTH: ALU operand b (latched multiplicand, or 0 when the multiplier bit is 0).
- `alu_sub`  out  1: ALU subtract select. Constant 0.
- `alu_en`  out  1: ALU output enable. High only in ITER.
- `busy`  out  1: high in ITER.
- `done`  out  1: single-cycle pulse, high in DONE.
- `product`  out  2·WIDTH: registered result. Holds until the next completion.
- `ovf`  out  1: `product[2W-1:W] != 0`, registered with `product`.
- `zero`  out  1: `product == 0`, registered with `product`.

## Operation
- FSM states are IDLE, ITER and DONE. All state is reset by `flag_clr` to IDLE.
- Reset values:
  - `product`=0, `ovf`=0, `zero`=0, `busy`=0, `done`=0, `alu_en`=0.
  - `alu_a`=0, `alu_b`=0, `alu_sub`=0.
  - Internal registers `acc`, `q`, `m` and `cnt` are all 0.
- IDLE, when `start`=1:
  - `m`←`mcand`, `q`←`mplier`, `acc`←0, `cnt`←0.
  - Go to ITER.
- ITER, every cycle:
  - `alu_a`=`acc`. `alu_b` = `q[0] ? m : 0`.
  - Local carry `c` = (`alu_ans` < `acc`), i.e. unsigned wrap detection. The registered ALU carry is deliberately not used.
  - Shift right by one: `{acc,q}` ← `{c, alu_ans, q[W-1:1]}`.
  - `cnt`←`cnt`+1.
- On the iteration where `cnt`==W-1, additionally load `product` from the shifted `{acc,q}` and update `ovf`/`zero`. Then go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` in ITER or DONE is ignored and not queued. If `start` is held high, the next operation is accepted on the first IDLE cycle.
- `mcand` and `mplier` may change freely after acceptance.
- Reset mid-operation: the operation is aborted, all outputs take their reset values, and the previous `product` is lost.
- Arithmetic is unsigned only. The maximum product 255·255 = 0xFE01 fits in 2·W bits with no truncation.

## Timing
- Edge 0: `start` sampled in IDLE.
- Edges 1..W: iterations.
- After edge W: `product` valid and `done`=1.
- After edge W+1: back in IDLE.
- Latency from start-accept edge to `done` high: W cycles (8). Issue interval: W+2 cycles.
- `alu_a`, `alu_b` and `alu_en` are combinational from registered state. `alu_ans` must settle within the same cycle, which gives a single-cycle path through the ALU adder.
- `product`, `ovf` and `zero` change only on the final ITER edge or on reset.
- `flag_clr` acts immediately and asynchronously. Its deassertion must be synchronous to `flag_clk`.

## Structure
- Package `alu_pkg` holds:
  - the state enum `mul_state_t` (IDLE, ITER, DONE);
  - `ALU_WIDTH`=8;
  - the iteration-count constant.
- There is no sub-module. The ALU instance lives in the parent datapath and is connected through the `alu_*` ports.
- The bench instantiates the real ALU alongside this block.

## Test plan
- 13×11 with one start pulse → `done` exactly 8 cycles after accept, `product`=0x008F, `ovf`=0, `zero`=0.
- 255×255 → `product`=0xFE01 and `ovf`=1. Local carry must be set on the wrap iterations.
- 0×200 and 200×0 → `product`=0x0000, `zero`=1. `alu_b`=0 on every iteration of 200×0.
- `start` re-pulsed with different operands during ITER → ignored. `product` reflects the first operands only and `done` pulses once.
- `flag_clr` asserted at iteration 4 → all outputs immediately at reset values. A fresh 7×9 then gives 0x003F.
- `start` held high continuously for 3 operations → accepts at IDLE every 10 cycles. `done` pulses are 1 cycle wide, and `alu_en`=0 outside ITER.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU-side multiply sequencer.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int MUL_ITERS = ALU_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier borrowing the external ALU adder; product and done after WIDTH cycles.
// No backpressure: start is only sampled in IDLE, requests in ITER/DONE are dropped, done is a 1-cycle pulse.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_ITERS
) (
  input  logic                 flag_clk,
  input  logic                 flag_clr,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic [WIDTH-1:0]     alu_ans,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_sub,
  output logic                 alu_en,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf,
  output logic                 zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mul_state_t           state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;

  logic                 in_iter;
  logic                 carry;
  logic [2*WIDTH-1:0]   shifted;

  assign in_iter = (state_q == ITER);
  // The ALU only returns WIDTH bits, so the ninth sum bit is recovered from wrap-around.
  assign carry   = (alu_ans < acc_q);
  assign shifted = {carry, alu_ans, q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mcand;
          q_d     = mplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        acc_d = shifted[2*WIDTH-1:WIDTH];
        q_d   = shifted[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          product_d = shifted;
          ovf_d     = |shifted[2*WIDTH-1:WIDTH];
          zero_d    = ~|shifted;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge flag_clk or posedge flag_clr) begin
    if (flag_clr) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign alu_a   = acc_q;
  assign alu_b   = (in_iter && q_q[0]) ? m_q : '0;
  assign alu_sub = 1'b0;
  assign alu_en  = in_iter;
  assign busy    = in_iter;
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign ovf     = ovf_q;
  assign zero    = zero_q;

endmodule
